// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Opcode constants, branch-kind encoding and decode helper for
//               the SPU branch unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam logic [2:0] FMT_RR   = 3'd0;
    localparam logic [2:0] FMT_RI16 = 3'd1;

    localparam logic [10:0] OP_BI    = 11'b00110101000;
    localparam logic [10:0] OP_BIZ   = 11'b00100101000;
    localparam logic [10:0] OP_BINZ  = 11'b00100101001;
    localparam logic [10:0] OP_BIHZ  = 11'b00100101010;
    localparam logic [10:0] OP_BINZH = 11'b00100101011;

    localparam logic [8:0] OP_BR    = 9'b001100100;
    localparam logic [8:0] OP_BRA   = 9'b001100000;
    localparam logic [8:0] OP_BRSL  = 9'b001100110;
    localparam logic [8:0] OP_BRASL = 9'b001100010;
    localparam logic [8:0] OP_BRZ   = 9'b001000000;
    localparam logic [8:0] OP_BRNZ  = 9'b001000010;
    localparam logic [8:0] OP_BRZH  = 9'b001000100;
    localparam logic [8:0] OP_BRNZH = 9'b001000110;

    typedef enum logic [2:0] {
        UNCOND, ABS, IND, Z_W, NZ_W, Z_H, NZ_H, NOP
    } br_kind_e;

    // kind selects the condition; ind selects the register-indirect target
    typedef struct packed {
        br_kind_e kind;
        logic     ind;
        logic     link;
    } br_dec_t;

    // op bit 10 is the architectural bit 0; RI16 opcodes occupy op[10:2]
    function automatic br_dec_t decode_branch(input logic [2:0] fmt, input logic [10:0] op);
        br_dec_t d;
        d.kind = NOP;
        d.ind  = 1'b0;
        d.link = 1'b0;
        if (fmt == FMT_RR) begin
            case (op)
                OP_BI:    d.kind = IND;
                OP_BIZ:   d.kind = Z_W;
                OP_BINZ:  d.kind = NZ_W;
                OP_BIHZ:  d.kind = Z_H;
                OP_BINZH: d.kind = NZ_H;
                default:  d.kind = NOP;
            endcase
            d.ind = (d.kind != NOP);
        end else if (fmt == FMT_RI16) begin
            case (op[10:2])
                OP_BR:    d.kind = UNCOND;
                OP_BRA:   d.kind = ABS;
                OP_BRSL:  begin d.kind = UNCOND; d.link = 1'b1; end
                OP_BRASL: begin d.kind = ABS;    d.link = 1'b1; end
                OP_BRZ:   d.kind = Z_W;
                OP_BRNZ:  d.kind = NZ_W;
                OP_BRZH:  d.kind = Z_H;
                OP_BRNZH: d.kind = NZ_H;
                default:  d.kind = NOP;
            endcase
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_unit_pipe_if.sv
// ============================================================================
// Module      : branch_unit_pipe_if
// Description : Issue, redirect and writeback signals of the branch unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface branch_unit_pipe_if #(
    parameter int PC_WIDTH = 8,
    parameter int DATA_W   = 128,
    parameter int RADDR_W  = 7
);
    logic                in_valid;
    logic                stall;
    logic                flush;
    logic [10:0]         op_code;
    logic [2:0]          instr_format;
    logic [RADDR_W-1:0]  dest_reg_addr;
    logic [DATA_W-1:0]   src_reg_a;
    logic [DATA_W-1:0]   store_reg;
    logic [17:0]         imm_value;
    logic                enable_reg_write;
    logic [PC_WIDTH-1:0] program_counter_input;
    logic                initial_;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                disable_branch;
    logic                wb_valid;
    logic [DATA_W-1:0]   wb_data;
    logic [RADDR_W-1:0]  wb_reg_addr;
    logic                wb_enable_reg_write;

    modport master (
        output in_valid, stall, flush, op_code, instr_format, dest_reg_addr,
               src_reg_a, store_reg, imm_value, enable_reg_write,
               program_counter_input, initial_,
        input  redirect_valid, redirect_pc, disable_branch,
               wb_valid, wb_data, wb_reg_addr, wb_enable_reg_write
    );

    modport slave (
        input  in_valid, stall, flush, op_code, instr_format, dest_reg_addr,
               src_reg_a, store_reg, imm_value, enable_reg_write,
               program_counter_input, initial_,
        output redirect_valid, redirect_pc, disable_branch,
               wb_valid, wb_data, wb_reg_addr, wb_enable_reg_write
    );
endinterface

`default_nettype wire

// File: rtl/branch_wb_delay.sv
// ============================================================================
// Module      : branch_wb_delay
// Description : DEPTH-deep writeback shift pipe with stall hold and flush kill.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_wb_delay #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 128,
    parameter int RADDR_W = 7
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic               i_stall,
    input  wire logic               i_flush,
    input  wire logic               i_valid,
    input  wire logic [DATA_W-1:0]  i_data,
    input  wire logic [RADDR_W-1:0] i_reg_addr,
    input  wire logic               i_reg_write,
    output logic                    o_valid,
    output logic [DATA_W-1:0]       o_data,
    output logic [RADDR_W-1:0]      o_reg_addr,
    output logic                    o_reg_write
);

    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_we;
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [RADDR_W-1:0] r_addr [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_we    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_addr[i] <= '0;
            end
        end else if (i_flush) begin
            // payload may stay stale; only the qualifiers matter
            r_valid <= '0;
            r_we    <= '0;
        end else if (!i_stall) begin
            r_valid[0] <= i_valid;
            r_we[0]    <= i_reg_write;
            r_data[0]  <= i_data;
            r_addr[0]  <= i_reg_addr;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_we[i]    <= r_we[i-1];
                r_data[i]  <= r_data[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign o_valid     = r_valid[DEPTH-1];
    assign o_reg_write = r_we[DEPTH-1];
    assign o_data      = r_data[DEPTH-1];
    assign o_reg_addr  = r_addr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/branch_unit_pipe.sv
// ============================================================================
// Module      : branch_unit_pipe
// Description : SPU branch resolve with registered redirect and delayed link writeback.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_unit_pipe
    import branch_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter int LATENCY  = 4,
    parameter int DATA_W   = 128,
    parameter int RADDR_W  = 7
) (
    input wire logic          clock,
    input wire logic          reset,
    branch_unit_pipe_if.slave bus
);

    br_dec_t             w_dec;
    logic                w_issue;
    logic                w_taken;
    logic [31:0]         w_ra_word;
    logic [31:0]         w_rt_word;
    logic [15:0]         w_imm16;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [DATA_W-1:0]   w_wb_data;
    logic                w_wb_we;
    logic                w_unused_bits;

    logic                r_redirect_valid;
    logic [PC_WIDTH-1:0] r_redirect_pc;
    logic                r_disable_branch;

    assign w_dec     = decode_branch(bus.instr_format, bus.op_code);
    assign w_issue   = bus.in_valid & ~bus.stall & ~bus.flush;
    // architectural word 0 is the most significant word of the register
    assign w_ra_word = bus.src_reg_a[DATA_W-1 -: 32];
    assign w_rt_word = bus.store_reg[DATA_W-1 -: 32];
    assign w_imm16   = bus.imm_value[15:0];
    assign w_pc_inc  = bus.program_counter_input + PC_WIDTH'(1);
    assign w_wb_data = w_dec.link ? {32'(w_pc_inc), {(DATA_W-32){1'b0}}} : '0;
    assign w_wb_we   = w_dec.link & bus.enable_reg_write;

    assign w_unused_bits = ^{bus.imm_value[17:16], bus.src_reg_a[DATA_W-33:0],
                             bus.store_reg[DATA_W-33:0]};

    always_comb begin
        w_taken  = 1'b0;
        w_target = bus.program_counter_input + PC_WIDTH'($signed(w_imm16));
        case (w_dec.kind)
            UNCOND, ABS, IND: w_taken = 1'b1;
            Z_W:              w_taken = (w_rt_word == 32'd0);
            NZ_W:             w_taken = (w_rt_word != 32'd0);
            Z_H:              w_taken = (w_rt_word[15:0] == 16'd0);
            NZ_H:             w_taken = (w_rt_word[15:0] != 16'd0);
            default:          w_taken = 1'b0;
        endcase
        if (w_dec.kind == ABS)
            w_target = PC_WIDTH'(w_imm16);
        else if (w_dec.ind)
            w_target = PC_WIDTH'(w_ra_word >> 2);
    end

    // redirect is a pulse: any edge without an issue (stall, flush, idle) drops it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_disable_branch <= 1'b0;
        end else begin
            r_redirect_valid <= w_issue & w_taken;
            r_disable_branch <= w_issue & w_taken & bus.initial_;
            if (w_issue)
                r_redirect_pc <= w_target;
        end
    end

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.disable_branch = r_disable_branch;

    branch_wb_delay #(
        .DEPTH   (LATENCY),
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_wb_delay (
        .clock       (clock),
        .reset       (reset),
        .i_stall     (bus.stall),
        .i_flush     (bus.flush),
        .i_valid     (w_issue),
        .i_data      (w_wb_data),
        .i_reg_addr  (bus.dest_reg_addr),
        .i_reg_write (w_wb_we),
        .o_valid     (bus.wb_valid),
        .o_data      (bus.wb_data),
        .o_reg_addr  (bus.wb_reg_addr),
        .o_reg_write (bus.wb_enable_reg_write)
    );

endmodule

`default_nettype wire

// File: tb/tb_branch_unit_pipe.sv
// ============================================================================
// Module      : tb_branch_unit_pipe
// Description : Directed scoreboard bench for branch_unit_pipe.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_unit_pipe;

    localparam int c_lat = 4;

    localparam logic [2:0]  c_rr   = 3'd0;
    localparam logic [2:0]  c_ri   = 3'd1;
    localparam logic [10:0] c_br    = {9'b001100100, 2'b00};
    localparam logic [10:0] c_bra   = {9'b001100000, 2'b00};
    localparam logic [10:0] c_brsl  = {9'b001100110, 2'b00};
    localparam logic [10:0] c_brasl = {9'b001100010, 2'b00};
    localparam logic [10:0] c_brz   = {9'b001000000, 2'b00};
    localparam logic [10:0] c_brnz  = {9'b001000010, 2'b00};
    localparam logic [10:0] c_brzh  = {9'b001000100, 2'b00};
    localparam logic [10:0] c_brnzh = {9'b001000110, 2'b00};
    localparam logic [10:0] c_bi    = 11'b00110101000;
    localparam logic [10:0] c_biz   = 11'b00100101000;

    typedef struct {
        int         due;
        logic [7:0] pc;
        logic       dis;
    } redir_t;

    typedef struct {
        int           left;
        logic [127:0] data;
        logic [6:0]   addr;
        logic         we;
    } wb_t;

    logic   clock;
    logic   reset;
    int     cyc;
    int     n_vec;
    int     n_err;
    redir_t rq[$];
    wb_t    wq[$];

    branch_unit_pipe_if #(.PC_WIDTH(8), .DATA_W(128), .RADDR_W(7)) bus ();

    branch_unit_pipe #(
        .PC_WIDTH (8),
        .LATENCY  (c_lat),
        .DATA_W   (128),
        .RADDR_W  (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".redirect_valid"}, 128'(bus.redirect_valid), 128'd0);
        chk({tag, ".redirect_pc"}, 128'(bus.redirect_pc), 128'd0);
        chk({tag, ".disable_branch"}, 128'(bus.disable_branch), 128'd0);
        chk({tag, ".wb_valid"}, 128'(bus.wb_valid), 128'd0);
        chk({tag, ".wb_data"}, bus.wb_data, 128'd0);
        chk({tag, ".wb_reg_addr"}, 128'(bus.wb_reg_addr), 128'd0);
        chk({tag, ".wb_enable_reg_write"}, 128'(bus.wb_enable_reg_write), 128'd0);
    endtask

    // one clock edge, then compare outputs against the scoreboard heads
    task automatic tick();
        logic adv;
        logic fl;
        redir_t r;
        wb_t    w;
        adv = reset && !bus.stall && !bus.flush;
        fl  = bus.flush;
        @(posedge clock);
        cyc++;
        if (fl || !reset) begin
            rq.delete();
            wq.delete();
        end else if (adv) begin
            foreach (wq[i]) wq[i].left--;
        end
        #1;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            chk("redirect_valid", 128'(bus.redirect_valid), 128'd1);
            chk("redirect_pc", 128'(bus.redirect_pc), 128'(r.pc));
            chk("disable_branch", 128'(bus.disable_branch), 128'(r.dis));
        end else begin
            chk("redirect_idle", 128'(bus.redirect_valid), 128'd0);
            chk("disable_idle", 128'(bus.disable_branch), 128'd0);
        end
        if (wq.size() > 0 && wq[0].left == 0) begin
            w = wq.pop_front();
            chk("wb_valid", 128'(bus.wb_valid), 128'd1);
            chk("wb_data", bus.wb_data, w.data);
            chk("wb_reg_addr", 128'(bus.wb_reg_addr), 128'(w.addr));
            chk("wb_enable_reg_write", 128'(bus.wb_enable_reg_write), 128'(w.we));
        end else begin
            chk("wb_idle", 128'(bus.wb_valid), 128'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [2:0] fmt, input logic [10:0] op, input logic [17:0] imm,
                        input logic [7:0] pc, input logic [31:0] ra, input logic [31:0] rt,
                        input logic [6:0] rd, input logic en, input logic ini,
                        input logic exp_tk, input logic [7:0] exp_pc,
                        input logic [31:0] exp_w0, input logic exp_we);
        redir_t r;
        wb_t    w;
        bus.in_valid              = 1'b1;
        bus.instr_format          = fmt;
        bus.op_code               = op;
        bus.imm_value             = imm;
        bus.program_counter_input = pc;
        bus.src_reg_a             = {ra, 96'hA5A5_A5A5_0F0F_0F0F_1234_5678};
        bus.store_reg             = {rt, 96'h5A5A_5A5A_F0F0_F0F0_8765_4321};
        bus.dest_reg_addr         = rd;
        bus.enable_reg_write      = en;
        bus.initial_              = ini;
        if (!bus.stall && !bus.flush) begin
            if (exp_tk) begin
                r.due = cyc + 1;
                r.pc  = exp_pc;
                r.dis = ini;
                rq.push_back(r);
            end
            w.left = c_lat;
            w.data = {exp_w0, 96'd0};
            w.addr = rd;
            w.we   = exp_we;
            wq.push_back(w);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b0;
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.op_code = '0; bus.instr_format = '0; bus.dest_reg_addr = '0;
        bus.src_reg_a = '0; bus.store_reg = '0; bus.imm_value = '0;
        bus.enable_reg_write = 1'b0; bus.program_counter_input = '0; bus.initial_ = 1'b0;

        @(posedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        idle(2);

        //    fmt   op       imm       pc     ra          rt            rd  en ini tk  pc     w0            we
        send(c_ri, c_br,    18'h0000C, 8'h10, 32'h0,      32'h0,        5, 1, 0, 1, 8'h1C, 32'h0,        0);
        send(c_ri, c_brsl,  18'h3FFFC, 8'h20, 32'h0,      32'h0,        3, 1, 0, 1, 8'h1C, 32'h00000021, 1);
        send(c_ri, c_brz,   18'h00004, 8'h30, 32'h0,      32'h5204ED1A, 4, 1, 0, 0, 8'h00, 32'h0,        0);
        send(c_ri, c_brz,   18'h00004, 8'h30, 32'h0,      32'h0,        4, 1, 0, 1, 8'h34, 32'h0,        0);
        send(c_ri, c_brzh,  18'h00010, 8'h40, 32'h0,      32'h52040000, 6, 0, 0, 1, 8'h50, 32'h0,        0);
        send(c_rr, c_biz,   18'h00000, 8'h60, 32'h130,    32'h0,        7, 1, 0, 1, 8'h4C, 32'h0,        0);
        send(c_ri, c_br,    18'h00002, 8'hFF, 32'h0,      32'h0,        1, 0, 1, 1, 8'h01, 32'h0,        0);
        send(c_ri, c_br,    18'h00002, 8'hFF, 32'h0,      32'h0,        1, 0, 0, 1, 8'h01, 32'h0,        0);
        send(c_ri, c_brnz,  18'h3FFF0, 8'h70, 32'h0,      32'h00000001, 2, 1, 1, 1, 8'h60, 32'h0,        0);
        send(c_ri, c_brnzh, 18'h00008, 8'h70, 32'h0,      32'h52040000, 2, 1, 0, 0, 8'h00, 32'h0,        0);
        send(c_rr, c_bi,    18'h00000, 8'h12, 32'h400,    32'h0,        8, 1, 0, 1, 8'h00, 32'h0,        0);
        send(c_ri, c_bra,   18'h000C3, 8'h99, 32'h0,      32'h0,        8, 1, 0, 1, 8'hC3, 32'h0,        0);
        send(3'd2, c_brsl,  18'h00004, 8'h50, 32'h0,      32'h0,        9, 1, 1, 0, 8'h00, 32'h0,        0);
        send(c_ri, 11'h7FF, 18'h00004, 8'h50, 32'h0,      32'h0,        9, 1, 0, 0, 8'h00, 32'h0,        0);
        idle(c_lat + 2);

        // stall: issue blocked while stalled, writeback slides by the stall count
        send(c_ri, c_brasl, 18'h00040, 8'h05, 32'h0,      32'h0,       10, 1, 0, 1, 8'h40, 32'h00000006, 1);
        bus.stall = 1'b1;
        send(c_ri, c_br,    18'h00001, 8'h77, 32'h0,      32'h0,       11, 1, 0, 1, 8'h78, 32'h0,        0);
        idle(2);
        bus.stall = 1'b0;
        idle(c_lat + 2);

        // flush: two in flight plus one presented with flush are all dropped
        send(c_ri, c_br,    18'h00001, 8'h10, 32'h0,      32'h0,       12, 1, 0, 1, 8'h11, 32'h0,        0);
        send(c_ri, c_brsl,  18'h00001, 8'h20, 32'h0,      32'h0,       13, 1, 1, 1, 8'h21, 32'h00000021, 1);
        bus.flush = 1'b1;
        send(c_ri, c_br,    18'h00001, 8'h30, 32'h0,      32'h0,       14, 1, 0, 1, 8'h31, 32'h0,        0);
        chk("flush_wb_we", 128'(bus.wb_enable_reg_write), 128'd0);
        bus.flush = 1'b0;
        idle(c_lat + 2);

        // asynchronous reset with three entries in flight
        send(c_ri, c_br,    18'h00001, 8'h10, 32'h0,      32'h0,        1, 1, 0, 1, 8'h11, 32'h0,        0);
        send(c_ri, c_brsl,  18'h00001, 8'h20, 32'h0,      32'h0,        2, 1, 1, 1, 8'h21, 32'h00000021, 1);
        send(c_ri, c_brsl,  18'h00002, 8'h30, 32'h0,      32'h0,        3, 1, 1, 1, 8'h32, 32'h00000031, 1);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        rq.delete();
        wq.delete();
        idle(2);
        #3;
        reset = 1'b1;
        send(c_ri, c_bra,   18'h0000C, 8'h44, 32'h0,      32'h0,        5, 1, 0, 1, 8'h0C, 32'h0,        0);
        idle(c_lat + 2);

        chk("scoreboard_empty", 128'(rq.size() + wq.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
